raycast_column_renderer: RTL and testbench
==========================================

# raycast_column_renderer

Parametrised raycast wall renderer between the Avalon-MM bus and the VGA pixel stream. Software writes one entry per screen column: wall half-height plus shade index. Entries go into a back buffer that swaps with the front buffer at the next vertical sync, so frames never tear. The pixel side turns `DrawX`/`DrawY` from `vga_controller` into registered 12-bit RGB using programmable ceiling, floor and palette colours.

## Interface
Parameters:
- `SCREEN_W`, 640: visible pixels per line.
- `SCREEN_H`, 480: visible lines.
- `COL_SHIFT`, 1: screen pixels per column = 2^COL_SHIFT; `NUM_COLS` = SCREEN_W >> COL_SHIFT.
- `HEIGHT_W`, 9: width of the half-height field.
- `SHADE_W`, 4: width of the shade index; palette depth = 2^SHADE_W.
- `ADDR_W`, 12: Avalon word-address width.

Ports:
- `CLK` in 1: single clock (50 MHz).
- `RESET` in 1: asynchronous, active-high.
- `PIX_CE` in 1: pixel-clock enable. The pixel pipeline advances only when it is 1.
- `AVL_READ`, `AVL_WRITE`, `AVL_CS` in 1: Avalon-MM strobes; ignored unless CS=1.
- `AVL_ADDR` in ADDR_W: word address.
- `AVL_WRITEDATA` in 32: write data.
- `AVL_READDATA` out 32: read data, fixed read latency 1.
- `draw_x`, `draw_y` in 10: pixel coordinates from `vga_controller`.
- `blank` in 1: 1 = visible area (same sense as `vga_controller`).
- `hs_in`, `vs_in` in 1: syncs, active-low.
- `red`, `green`, `blue` out 4: pixel colour.
- `hs`, `vs` out 1: syncs delayed to align with the colour outputs.
- `frame_swapped` out 1: one-CLK pulse on each buffer swap.

## Operation
Register map (word addresses):
- 0..NUM_COLS-1: column entry.
  - Bits [HEIGHT_W-1:0] = half-height h.
  - Bits [16+SHADE_W-1:16] = shade index s.
  - Writes go to the back buffer. Reads return the back buffer.
- NUM_COLS+0: CTRL.
  - Bit0 SWAP_REQ: write 1 sets pending; reads return pending.
  - Bit1 FRONT_SEL: read-only.
- NUM_COLS+1: CEIL_COLOR, bits [11:0] = {R,G,B}.
- NUM_COLS+2: FLOOR_COLOR, bits [11:0].
- NUM_COLS+16 .. NUM_COLS+16+2^SHADE_W-1: palette entries, bits [11:0].
- Unmapped addresses: reads return 0, writes are ignored.

Pixel path, per pixel:
- col = draw_x >> COL_SHIFT; fetch the front-buffer entry for col.
- hc = min(h, SCREEN_H/2), saturating.
- top = SCREEN_H/2 - hc; bot = SCREEN_H/2 + hc.
- Output colour:
  - blank=0: black.
  - draw_y < top: CEIL_COLOR.
  - draw_y >= bot: FLOOR_COLOR.
  - otherwise: palette[s].
- h=0 gives no wall rows (ceiling then floor).

Buffer swap (state IDLE/PENDING):
- A write of 1 to SWAP_REQ moves IDLE→PENDING.
- In PENDING, the first PIX_CE cycle where `vs_in` samples 1→0 (vsync start) does the following, then returns to IDLE:
  - toggles FRONT_SEL;
  - pulses `frame_swapped`;
  - clears pending.
- If a SWAP_REQ write lands in the same cycle as the vsync edge, the swap occurs on that edge.
- Column writes in that cycle land in the buffer that was back before the swap.
- Repeated SWAP_REQ writes while PENDING have no extra effect.

## Timing
- Pixel latency: 2 PIX_CE cycles from `draw_x`/`draw_y`/`blank`/`hs_in`/`vs_in` to `red`/`green`/`blue`/`hs`/`vs`.
  - Stage 0: input register and synchronous RAM read.
  - Stage 1: compare, colour select and output register.
- Avalon: writes take effect at the next CLK edge; readdata is valid 1 CLK after `AVL_READ`; no waitrequest.
- Reset values:
  - `red`/`green`/`blue` = 0; `hs` = `vs` = 1.
  - FRONT_SEL = 0; pending = 0; `frame_swapped` = 0; `AVL_READDATA` = 0.
  - CEIL_COLOR = 0x000; FLOOR_COLOR = 0x444; palette all 0.
  - Column RAMs are not reset; contents are undefined until written.
- `RESET` asserted mid-frame or mid-pending: outputs return to reset values immediately; a pending swap is lost.

## Configuration
- `RCR_FOG_EN` defined: wall colour is dimmed by distance.
  - Shift amount f = 3 - h[HEIGHT_W-1:HEIGHT_W-2] (taken from hc).
  - Each 4-bit channel of palette[s] is right-shifted by f.
  - Latency is unchanged.
- Undefined: wall colour is exactly palette[s].

## Structure
- Package `raycast_pkg` holds:
  - the column-entry typedef (height, shade fields);
  - the 12-bit colour typedef;
  - the register-offset constants (CTRL, CEIL, FLOOR, PAL_BASE);
  - the swap-state enum.
- Sub-module `column_ram`: simple dual-port RAM, NUM_COLS × 32 bits, one write port and two synchronous read ports (Avalon readback and pixel fetch).
  - Two instances form the ping-pong buffers; FRONT_SEL muxes them.

## Test plan
1. Reset, no writes, blank=1: outputs are 0 before the first PIX_CE; after 2 PIX_CE, pixel (0, 0) is 0x000 (ceiling), `hs` = `vs` = 1.
2. Write col 5 = {s=2, h=100}, palette[2] = 0xF00, swap at vsync. With COL_SHIFT=1:
   - x=10, y=139 → ceiling;
   - x=10, y=140 and y=339 → 0xF00;
   - x=10, y=340 → floor 0x444.
3. h=300: saturates; the whole column is the palette colour for y = 0..479.
4. SWAP_REQ written 3 cycles before the vsync edge, column writes after the edge: exactly one `frame_swapped` pulse; FRONT_SEL=1; the late writes are not visible until the next swap.
5. SWAP_REQ write in the same cycle as the vsync edge: the swap happens on that edge and pending reads 0 afterwards.
6. `RCR_FOG_EN` build, h=64 (top bits 00), palette 0xFFF: wall pixels read 0x111.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared types and register offsets for the raycast column renderer.
// Contents: column-entry layout, 12-bit colour type, register offsets
// relative to NUM_COLS, and the buffer-swap state enum.
package raycast_pkg;

   // Column entry as stored in the RAMs: shade in [31:16], height in [15:0].
   // Only the low SHADE_W / HEIGHT_W bits of each field are meaningful.
   typedef struct packed {
      logic [15:0] shade;
      logic [15:0] height;
   } col_entry_t;

   typedef logic [11:0] rgb12_t;

   localparam int REG_CTRL     = 0;
   localparam int REG_CEIL     = 1;
   localparam int REG_FLOOR    = 2;
   localparam int REG_PAL_BASE = 16;

   localparam rgb12_t FLOOR_RST = 12'h444;

   typedef enum logic {
      SW_IDLE    = 1'b0,
      SW_PENDING = 1'b1
   } swap_state_t;

endpackage

// File: rtl/raycast_column_renderer_column_ram.sv
// column_ram: simple dual-port column buffer, DEPTH x 32 bits.
// Ports:
//   clk_i                 clock
//   we_i/waddr_i/wdata_i  write port
//   raddr_a_i/rdata_a_o   synchronous read port A (bus readback)
//   re_b_i/raddr_b_i/rdata_b_o  synchronous read port B with enable (pixel fetch)
// Contents are not reset.
module column_ram
   import raycast_pkg::*;
#(
   parameter int DEPTH = 320,
   parameter int AW    = 9
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  col_entry_t    wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output col_entry_t    rdata_a_o,
   input  logic          re_b_i,
   input  logic [AW-1:0] raddr_b_i,
   output col_entry_t    rdata_b_o
);

   col_entry_t mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      rdata_a_o <= mem[raddr_a_i];
      if (re_b_i) rdata_b_o <= mem[raddr_b_i];
   end

endmodule

// File: rtl/raycast_column_renderer.sv
// raycast_column_renderer: Avalon-MM programmable column wall renderer.
// Software writes per-column {shade, half-height} entries into a back
// buffer; the buffers swap at the next vsync start after a SWAP_REQ.
// The pixel side maps draw_x/draw_y to ceiling / wall / floor colours with
// a 2-PIX_CE latency.
// Ports:
//   CLK, RESET (async, active-high), PIX_CE (pixel enable)
//   AVL_*            Avalon-MM slave, read latency 1, no waitrequest
//   draw_x, draw_y, blank, hs_in, vs_in   from vga_controller
//   red, green, blue, hs, vs              aligned pixel outputs
//   frame_swapped    one-CLK pulse per buffer swap
// Build option: define RCR_FOG_EN to dim wall colour by distance.
module raycast_column_renderer
   import raycast_pkg::*;
#(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int COL_SHIFT = 1,
   parameter int HEIGHT_W  = 9,
   parameter int SHADE_W   = 4,
   parameter int ADDR_W    = 12
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              PIX_CE,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic              AVL_CS,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [31:0]       AVL_WRITEDATA,
   output logic [31:0]       AVL_READDATA,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   input  logic              blank,
   input  logic              hs_in,
   input  logic              vs_in,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              hs,
   output logic              vs,
   output logic              frame_swapped
);

   localparam int NUM_COLS = SCREEN_W >> COL_SHIFT;
   localparam int COL_AW   = $clog2(NUM_COLS);
   localparam int PAL_N    = 1 << SHADE_W;
   localparam int HALF     = SCREEN_H / 2;
   localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(NUM_COLS + REG_CTRL);
   localparam logic [ADDR_W-1:0] A_CEIL  = ADDR_W'(NUM_COLS + REG_CEIL);
   localparam logic [ADDR_W-1:0] A_FLOOR = ADDR_W'(NUM_COLS + REG_FLOOR);
   localparam logic [ADDR_W-1:0] A_PAL   = ADDR_W'(NUM_COLS + REG_PAL_BASE);

   function automatic logic [HEIGHT_W-1:0] sat_half(input logic [HEIGHT_W-1:0] h);
      if (int'(h) > HALF) return HEIGHT_W'(HALF);
      return h;
   endfunction

`ifdef RCR_FOG_EN
   // Taller walls are nearer: top two height bits select a shift of 3..0.
   function automatic rgb12_t fog(input rgb12_t c, input logic [1:0] top2);
      logic [1:0] f;
      f = 2'd3 - top2;
      return {c[11:8] >> f, c[7:4] >> f, c[3:0] >> f};
   endfunction
`endif

   // ---------------- Avalon decode ----------------
   logic              wr_en, rd_en, col_hit, pal_hit;
   logic [ADDR_W-1:0] pal_off;
   logic [SHADE_W-1:0] pal_idx;
   logic [COL_AW-1:0] col_addr;

   assign wr_en    = AVL_CS & AVL_WRITE;
   assign rd_en    = AVL_CS & AVL_READ;
   assign col_hit  = AVL_ADDR < ADDR_W'(NUM_COLS);
   assign pal_off  = AVL_ADDR - A_PAL;
   assign pal_hit  = (AVL_ADDR >= A_PAL) && (pal_off < ADDR_W'(PAL_N));
   assign pal_idx  = pal_off[SHADE_W-1:0];
   assign col_addr = AVL_ADDR[COL_AW-1:0];

   // ---------------- Swap FSM ----------------
   swap_state_t state_q, state_d;
   logic        front_q, vs_prev_q, swap_wr, vs_edge, do_swap;

   assign swap_wr = wr_en && (AVL_ADDR == A_CTRL) && AVL_WRITEDATA[0];
   assign vs_edge = PIX_CE & vs_prev_q & ~vs_in;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= SW_IDLE;
      else       state_q <= state_d;
   end

   // A request landing on the edge itself is served immediately.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SW_IDLE:    if (swap_wr && !vs_edge) state_d = SW_PENDING;
         SW_PENDING: if (vs_edge) state_d = SW_IDLE;
         default:    state_d = SW_IDLE;
      endcase
   end

   always_comb begin
      do_swap = vs_edge && ((state_q == SW_PENDING) || swap_wr);
   end

   // ---------------- Control / colour registers ----------------
   rgb12_t ceil_q, floor_q;
   rgb12_t pal_q [PAL_N];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         front_q       <= 1'b0;
         vs_prev_q     <= 1'b1;
         frame_swapped <= 1'b0;
         ceil_q        <= 12'h000;
         floor_q       <= FLOOR_RST;
         for (int i = 0; i < PAL_N; i++) pal_q[i] <= 12'h000;
      end else begin
         frame_swapped <= do_swap;
         if (do_swap) front_q <= ~front_q;
         if (PIX_CE) vs_prev_q <= vs_in;
         if (wr_en && (AVL_ADDR == A_CEIL))  ceil_q  <= AVL_WRITEDATA[11:0];
         if (wr_en && (AVL_ADDR == A_FLOOR)) floor_q <= AVL_WRITEDATA[11:0];
         if (wr_en && pal_hit) pal_q[pal_idx] <= AVL_WRITEDATA[11:0];
      end
   end

   // ---------------- Column buffers ----------------
   col_entry_t ram0_a, ram1_a, ram0_b, ram1_b;
   logic [9:0] pix_col_full;
   logic       we0, we1;

   assign pix_col_full = draw_x >> COL_SHIFT;
   // Column writes go to whichever buffer is back before any same-cycle swap.
   assign we0 = wr_en & col_hit & front_q;
   assign we1 = wr_en & col_hit & ~front_q;

   column_ram #(.DEPTH(NUM_COLS), .AW(COL_AW)) u_ram0 (
      .clk_i(CLK), .we_i(we0), .waddr_i(col_addr), .wdata_i(AVL_WRITEDATA),
      .raddr_a_i(col_addr), .rdata_a_o(ram0_a),
      .re_b_i(PIX_CE), .raddr_b_i(pix_col_full[COL_AW-1:0]), .rdata_b_o(ram0_b)
   );

   column_ram #(.DEPTH(NUM_COLS), .AW(COL_AW)) u_ram1 (
      .clk_i(CLK), .we_i(we1), .waddr_i(col_addr), .wdata_i(AVL_WRITEDATA),
      .raddr_a_i(col_addr), .rdata_a_o(ram1_a),
      .re_b_i(PIX_CE), .raddr_b_i(pix_col_full[COL_AW-1:0]), .rdata_b_o(ram1_b)
   );

   // ---------------- Avalon readback ----------------
   logic [31:0] reg_rdata, rd_reg_q;
   logic        rd_col_q, rd_back_q;

   always_comb begin
      reg_rdata = 32'd0;
      if (AVL_ADDR == A_CTRL)       reg_rdata = {30'd0, front_q, state_q == SW_PENDING};
      else if (AVL_ADDR == A_CEIL)  reg_rdata = {20'd0, ceil_q};
      else if (AVL_ADDR == A_FLOOR) reg_rdata = {20'd0, floor_q};
      else if (pal_hit)             reg_rdata = {20'd0, pal_q[pal_idx]};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_col_q  <= 1'b0;
         rd_back_q <= 1'b0;
         rd_reg_q  <= 32'd0;
      end else begin
         rd_col_q  <= rd_en & col_hit;
         rd_back_q <= ~front_q;
         rd_reg_q  <= (rd_en && !col_hit) ? reg_rdata : 32'd0;
      end
   end

   // Column reads come straight from the RAM's registered output port.
   assign AVL_READDATA = rd_col_q ? (rd_back_q ? ram1_a : ram0_a) : rd_reg_q;

   // ---------------- Stage 0: input register + RAM fetch ----------------
   logic [9:0] y_p0_q;
   logic       blank_p0_q, hs_p0_q, vs_p0_q, fsel_p0_q;

   always_ff @(posedge CLK) begin
      if (PIX_CE) y_p0_q <= draw_y;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         blank_p0_q <= 1'b0;
         hs_p0_q    <= 1'b1;
         vs_p0_q    <= 1'b1;
         fsel_p0_q  <= 1'b0;
      end else if (PIX_CE) begin
         blank_p0_q <= blank;
         hs_p0_q    <= hs_in;
         vs_p0_q    <= vs_in;
         fsel_p0_q  <= front_q;
      end
   end

   // ---------------- Stage 1: compare, colour select, output ----------------
   col_entry_t          ent_p0;
   logic [HEIGHT_W-1:0] hc_p0;
   logic [SHADE_W-1:0]  shade_p0;
   logic [9:0]          top_p0, bot_p0;
   rgb12_t              wall_p0, pix_rgb_p0;
   logic                pix_unused;

   assign ent_p0   = fsel_p0_q ? ram1_b : ram0_b;
   assign hc_p0    = sat_half(ent_p0.height[HEIGHT_W-1:0]);
   assign shade_p0 = ent_p0.shade[SHADE_W-1:0];
   assign top_p0   = 10'(HALF) - 10'(hc_p0);
   assign bot_p0   = 10'(HALF) + 10'(hc_p0);
   assign pix_unused = ^{ent_p0.height[15:HEIGHT_W], ent_p0.shade[15:SHADE_W],
                         pix_col_full[9:COL_AW]};

`ifdef RCR_FOG_EN
   assign wall_p0 = fog(pal_q[shade_p0], hc_p0[HEIGHT_W-1 -: 2]);
`else
   assign wall_p0 = pal_q[shade_p0];
`endif

   always_comb begin
      pix_rgb_p0 = 12'h000;
      if (blank_p0_q) begin
         if (y_p0_q < top_p0)       pix_rgb_p0 = ceil_q;
         else if (y_p0_q >= bot_p0) pix_rgb_p0 = floor_q;
         else                       pix_rgb_p0 = wall_p0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         {red, green, blue} <= 12'h000;
         hs <= 1'b1;
         vs <= 1'b1;
      end else if (PIX_CE) begin
         {red, green, blue} <= pix_rgb_p0;
         hs <= hs_p0_q;
         vs <= vs_p0_q;
      end
   end

endmodule

// File: tb/tb_raycast_column_renderer.sv
module tb_raycast_column_renderer;

   localparam logic [11:0] A_CTRL  = 12'd320;
   localparam logic [11:0] A_CEIL  = 12'd321;
   localparam logic [11:0] A_FLOOR = 12'd322;
   localparam logic [11:0] A_UNMAP = 12'd325;
   localparam logic [11:0] A_PAL2  = 12'd338;
   localparam logic [11:0] A_PAL3  = 12'd339;

   // Wall colours hand-derived for each height used below.
`ifdef RCR_FOG_EN
   localparam logic [11:0] W100 = 12'h100;  // hc=100 top bits 00, F>>3
   localparam logic [11:0] W240 = 12'h300;  // hc=240 top bits 01, F>>2
   localparam logic [11:0] W10  = 12'h100;
   localparam logic [11:0] W64  = 12'h111;
`else
   localparam logic [11:0] W100 = 12'hF00;
   localparam logic [11:0] W240 = 12'hF00;
   localparam logic [11:0] W10  = 12'hF00;
   localparam logic [11:0] W64  = 12'hFFF;
`endif

   logic        CLK = 1'b0;
   logic        RESET, PIX_CE, AVL_READ, AVL_WRITE, AVL_CS;
   logic [11:0] AVL_ADDR;
   logic [31:0] AVL_WRITEDATA, AVL_READDATA;
   logic [9:0]  draw_x, draw_y;
   logic        blank, hs_in, vs_in;
   logic [3:0]  red, green, blue;
   logic        hs, vs, frame_swapped;

   always #5 CLK = ~CLK;

   raycast_column_renderer dut (
      .CLK(CLK), .RESET(RESET), .PIX_CE(PIX_CE),
      .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
      .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
      .draw_x(draw_x), .draw_y(draw_y), .blank(blank), .hs_in(hs_in), .vs_in(vs_in),
      .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs),
      .frame_swapped(frame_swapped)
   );

   typedef struct {
      int          due;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      string       name;
   } pix_exp_t;

   typedef struct {
      int          due;
      logic [31:0] data;
      string       name;
   } rd_exp_t;

   pix_exp_t pq[$];
   rd_exp_t  rq[$];
   int ce_cnt = 0, clk_cnt = 0, swaps = 0;
   int checks = 0, errors = 0;

   always @(posedge CLK) begin
      clk_cnt <= clk_cnt + 1;
      if (PIX_CE) ce_cnt <= ce_cnt + 1;
   end

   // Monitor: pops expectations once the DUT has produced the matching output.
   always @(negedge CLK) begin
      pix_exp_t pe;
      rd_exp_t  re;
      if (frame_swapped === 1'b1) swaps++;
      while (pq.size() > 0 && pq[0].due <= ce_cnt) begin
         pe = pq.pop_front();
         checks++;
         if ({red, green, blue, hs, vs} !== {pe.rgb, pe.hs, pe.vs}) begin
            errors++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                     pe.name, {red, green, blue}, hs, vs, pe.rgb, pe.hs, pe.vs);
         end
      end
      while (rq.size() > 0 && rq[0].due <= clk_cnt) begin
         re = rq.pop_front();
         checks++;
         if (AVL_READDATA !== re.data) begin
            errors++;
            $display("FAIL %s: got readdata=%h, want %h", re.name, AVL_READDATA, re.data);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask

   task automatic bus_idle();
      AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
   endtask

   task automatic idle();
      @(negedge CLK);
      bus_idle(); PIX_CE = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      @(negedge CLK);
      PIX_CE = 1'b0; AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
      AVL_ADDR = a; AVL_WRITEDATA = d;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
      rd_exp_t e;
      @(negedge CLK);
      PIX_CE = 1'b0; AVL_CS = 1'b1; AVL_WRITE = 1'b0; AVL_READ = 1'b1; AVL_ADDR = a;
      e.due = clk_cnt + 1; e.data = exp; e.name = nm;
      rq.push_back(e);
   endtask

   task automatic drive_pix(input int x, input int y, input logic bl, input logic h_s,
                            input logic v_s, input logic [11:0] exp, input string nm,
                            input logic do_chk);
      pix_exp_t e;
      PIX_CE = 1'b1; draw_x = 10'(x); draw_y = 10'(y);
      blank = bl; hs_in = h_s; vs_in = v_s;
      if (do_chk) begin
         e.due = ce_cnt + 2; e.rgb = exp; e.hs = h_s; e.vs = v_s; e.name = nm;
         pq.push_back(e);
      end
   endtask

   task automatic pix(input int x, input int y, input logic bl, input logic [11:0] exp,
                      input string nm);
      @(negedge CLK);
      bus_idle();
      drive_pix(x, y, bl, 1'b1, 1'b1, exp, nm, 1'b1);
   endtask

   task automatic vs_edge(input string nm);
      @(negedge CLK);
      bus_idle();
      drive_pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, nm, 1'b1);
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         bus_idle();
         drive_pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000, "", 1'b0);
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; PIX_CE = 1'b0; bus_idle();
      AVL_ADDR = '0; AVL_WRITEDATA = '0;
      draw_x = '0; draw_y = '0; blank = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;

      // Reset state, no PIX_CE yet
      repeat (2) idle();
      chk("rst_rgb", {20'd0, red, green, blue}, 32'h0);
      chk("rst_hs", {31'd0, hs}, 32'h1);
      chk("rst_vs", {31'd0, vs}, 32'h1);
      chk("rst_rdata", AVL_READDATA, 32'h0);
      chk("rst_swp", {31'd0, frame_swapped}, 32'h0);
      rd(A_CTRL, 32'h0, "rst_ctrl");
      rd(A_FLOOR, 32'h444, "rst_floor");
      rd(A_CEIL, 32'h000, "rst_ceil");
      rd(A_PAL2, 32'h000, "rst_pal2");
      pix(0, 0, 1'b1, 12'h000, "t1_pix00");
      flush();

      // Basic column, swap at vsync
      wr(A_CEIL, 32'h0A5);
      wr(A_PAL2, 32'hF00);
      wr(12'd5, 32'h0002_0064);
      wr(A_UNMAP, 32'hFFFF_FFFF);
      rd(A_UNMAP, 32'h0, "unmapped_rd");
      rd(12'd5, 32'h0002_0064, "col5_rb_back1");
      rd(A_PAL2, 32'hF00, "pal2_rb");
      wr(A_CTRL, 32'h1);
      rd(A_CTRL, 32'h1, "t2_pending");
      vs_edge("t2_vsedge");
      pix(0, 0, 1'b0, 12'h000, "t2_after_edge");
      rd(A_CTRL, 32'h2, "t2_front1");
      pix(10, 139, 1'b1, 12'h0A5, "t2_ceil_139");
      pix(10, 140, 1'b1, W100, "t2_wall_140");
      pix(11, 339, 1'b1, W100, "t2_wall_339");
      pix(10, 340, 1'b1, 12'h444, "t2_floor_340");
      pix(10, 200, 1'b0, 12'h000, "t2_blanked");
      @(negedge CLK); bus_idle();
      drive_pix(10, 200, 1'b1, 1'b0, 1'b1, W100, "t2_hs_low", 1'b1);
      flush();
      chk("t2_swaps", 32'(swaps), 32'd1);

      // Height saturation (h=300)
      wr(12'd5, 32'h0002_012C);
      rd(12'd5, 32'h0002_012C, "col5_rb_back0");
      wr(A_CTRL, 32'h1);
      vs_edge("t3_vsedge");
      pix(0, 0, 1'b0, 12'h000, "t3_after_edge");
      rd(A_CTRL, 32'h0, "t3_front0");
      pix(10, 0, 1'b1, W240, "t3_y0");
      pix(10, 240, 1'b1, W240, "t3_y240");
      pix(11, 479, 1'b1, W240, "t3_y479");
      flush();
      chk("t3_swaps", 32'(swaps), 32'd2);

      // SWAP_REQ three cycles before the edge, repeated; late writes hidden
      wr(A_CTRL, 32'h1);
      wr(A_CTRL, 32'h1);
      pix(0, 0, 1'b0, 12'h000, "t4_pre_edge");
      vs_edge("t4_vsedge");
      wr(12'd5, 32'h0002_000A);
      rd(A_CTRL, 32'h2, "t4_front1");
      pix(10, 250, 1'b1, W100, "t4_late_hidden");
      pix(10, 345, 1'b1, 12'h444, "t4_floor");
      flush();
      chk("t4_swaps", 32'(swaps), 32'd3);

      // SWAP_REQ write in the same cycle as the edge
      @(negedge CLK);
      AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
      AVL_ADDR = A_CTRL; AVL_WRITEDATA = 32'h1;
      drive_pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, "t5_vsedge", 1'b1);
      pix(0, 0, 1'b0, 12'h000, "t5_after_edge");
      rd(A_CTRL, 32'h0, "t5_ctrl");
      pix(10, 250, 1'b1, 12'h444, "t5_late_visible");
      pix(10, 245, 1'b1, W10, "t5_wall_245");
      pix(10, 230, 1'b1, W10, "t5_wall_230");
      pix(10, 229, 1'b1, 12'h0A5, "t5_ceil_229");
      flush();
      chk("t5_swaps", 32'(swaps), 32'd4);

      // Fog-sensitive wall (h=64, palette 0xFFF)
      wr(A_PAL3, 32'hFFF);
      wr(12'd20, 32'h0003_0040);
      wr(A_CTRL, 32'h1);
      vs_edge("t6_vsedge");
      pix(40, 175, 1'b1, 12'h0A5, "t6_ceil_175");
      pix(40, 176, 1'b1, W64, "t6_wall_176");
      pix(41, 303, 1'b1, W64, "t6_wall_303");
      pix(40, 304, 1'b1, 12'h444, "t6_floor_304");
      flush();
      chk("t6_swaps", 32'(swaps), 32'd5);

      // Reset while a swap is pending
      wr(A_CTRL, 32'h1);
      rd(A_CTRL, 32'h3, "t7_pending");
      idle();
      idle();
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("t7_rst_rgb", {20'd0, red, green, blue}, 32'h0);
      chk("t7_rst_sync", {30'd0, hs, vs}, 32'h3);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      rd(A_CTRL, 32'h0, "t7_pending_lost");
      rd(A_CEIL, 32'h000, "t7_ceil_rst");
      rd(A_PAL2, 32'h000, "t7_pal_rst");
      vs_edge("t7_vsedge");
      pix(10, 250, 1'b1, 12'h444, "t7_floor_rst");
      flush();
      chk("t7_no_swap", 32'(swaps), 32'd5);

      repeat (3) idle();
      chk("queues_drained", 32'(pq.size() + rq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
